// File: rtl/dmem_responder.sv
// Word-organised data memory for the core's MEM-stage port, with strobed sub-word
// writes and a valid/ready dump stream that walks every word without stalling the core.
module dmem_responder #(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] datamem_rd_addr0,
    output logic [31:0]       datamem_rd_dout0,
    input  logic              datamem_we0,
    input  logic [ADDR_W-1:0] datamem_wr_addr0,
    input  logic [31:0]       datamem_wr_din0,
    input  logic [2:0]        datamem_wr_strb,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [31:0]       dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    logic [31:0]       mem [DEPTH];
    logic [3:0]        byte_en;
    logic [31:0]       wr_data;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;

    // Sub-word data is replicated across lanes so each byte enable picks its own slice.
    always_comb begin
        byte_en = '0;
        wr_data = datamem_wr_din0;
        casez (datamem_wr_strb)
            3'b000: byte_en = 4'b1111;
            3'b001: begin
                byte_en = 4'b0011;
                wr_data = {2{datamem_wr_din0[15:0]}};
            end
            3'b011: begin
                byte_en = 4'b1100;
                wr_data = {2{datamem_wr_din0[15:0]}};
            end
            3'b1??: begin
                byte_en = 4'b0001 << datamem_wr_strb[1:0];
                wr_data = {4{datamem_wr_din0[7:0]}};
            end
            default: byte_en = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
        end else if (datamem_we0) begin
            if (byte_en[0]) mem[datamem_wr_addr0][7:0]   <= wr_data[7:0];
            if (byte_en[1]) mem[datamem_wr_addr0][15:8]  <= wr_data[15:8];
            if (byte_en[2]) mem[datamem_wr_addr0][23:16] <= wr_data[23:16];
            if (byte_en[3]) mem[datamem_wr_addr0][31:24] <= wr_data[31:24];
        end
    end

    assign datamem_rd_dout0 = mem[datamem_rd_addr0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    // Terminal word is tested before incrementing, so the pointer never wraps.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_nx = STREAM;
                    ptr_nx   = '0;
                end
            end
            STREAM: begin
                if (dump_ready) begin
                    if (ptr == ADDR_W'(DEPTH - 1)) begin
                        state_nx = DONE;
                    end else begin
                        ptr_nx = ptr + 1'b1;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign dump_valid = (state == STREAM);
    assign dump_busy  = (state == STREAM) || (state == DONE);
    assign dump_done  = (state == DONE);
    assign dump_addr  = ptr;
    assign dump_data  = mem[ptr];

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus queues expected reads and dump beats,
// a negedge monitor pops and compares them as the DUT presents data.
module tb_dmem_responder;

    localparam int unsigned DEPTH  = 128;
    localparam int unsigned ADDR_W = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [31:0]       rd_dout;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [31:0]       wr_din = '0;
    logic [2:0]        wr_strb = '0;
    logic              dump_start = 1'b0;
    logic              dump_valid;
    logic              dump_ready = 1'b1;
    logic [ADDR_W-1:0] dump_addr;
    logic [31:0]       dump_data;
    logic              dump_busy;
    logic              dump_done;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;
    logic rd_chk = 1'b0;
    logic [31:0] rd_q [$];
    logic [38:0] dump_q [$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .datamem_rd_addr0 (rd_addr),
        .datamem_rd_dout0 (rd_dout),
        .datamem_we0      (we),
        .datamem_wr_addr0 (wr_addr),
        .datamem_wr_din0  (wr_din),
        .datamem_wr_strb  (wr_strb),
        .dump_start       (dump_start),
        .dump_valid       (dump_valid),
        .dump_ready       (dump_ready),
        .dump_addr        (dump_addr),
        .dump_data        (dump_data),
        .dump_busy        (dump_busy),
        .dump_done        (dump_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [2:0] s);
        we = 1'b1; wr_addr = a; wr_din = d; wr_strb = s;
        tick();
        we = 1'b0;
    endtask

    task automatic rd_expect(input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        rd_addr = a;
        rd_q.push_back(exp);
        rd_chk = 1'b1;
        tick();
        rd_chk = 1'b0;
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        logic [38:0] e;
        logic [31:0] r;
        if (rd_chk) begin
            if (rd_q.size() == 0) begin
                chk("rd_queue_underflow", 64'd1, 64'd0);
            end else begin
                r = rd_q.pop_front();
                chk("rd_data", {32'd0, rd_dout}, {32'd0, r});
            end
        end
        if (dump_valid && dump_ready) begin
            if (dump_q.size() == 0) begin
                chk("dump_queue_underflow", 64'd1, 64'd0);
            end else begin
                e = dump_q.pop_front();
                chk("dump_addr", {57'd0, dump_addr}, {57'd0, e[38:32]});
                chk("dump_data", {32'd0, dump_data}, {32'd0, e[31:0]});
            end
        end
        if (dump_done) done_seen++;
    end

    initial begin
        int cnt, t, got, done_before;
        logic wrote, hold_chk, extra;

        // Reset, plant garbage, then reset again with a colliding write.
        rst = 1'b0; tick(); tick(); rst = 1'b1;
        chk("rst_valid", {63'd0, dump_valid}, 64'd0);
        chk("rst_busy",  {63'd0, dump_busy},  64'd0);
        chk("rst_done",  {63'd0, dump_done},  64'd0);
        chk("rst_addr",  {57'd0, dump_addr},  64'd0);
        chk("rst_data",  {32'd0, dump_data},  64'd0);
        for (int i = 0; i < 8; i++) wr(7'(i * 13), 32'hA5A5_0000 + 32'(i), 3'b000);
        rst = 1'b0; we = 1'b1; wr_addr = 7'd3; wr_din = 32'hFFFF_FFFF; wr_strb = 3'b000;
        tick();
        rst = 1'b1; we = 1'b0;
        for (int i = 0; i < DEPTH; i++) rd_expect(7'(i), 32'h0);

        // Word 5: SW, SB lane 2, SH low half.
        wr(7'd5, 32'hDEAD_BEEF, 3'b000); rd_expect(7'd5, 32'hDEAD_BEEF);
        wr(7'd5, 32'h0000_0011, 3'b110); rd_expect(7'd5, 32'hDE11_BEEF);
        wr(7'd5, 32'h0000_A5A5, 3'b001); rd_expect(7'd5, 32'hDE11_A5A5);

        // Word 7: high half, then three byte lanes.
        wr(7'd7, 32'h1234_BEEF, 3'b011); rd_expect(7'd7, 32'hBEEF_0000);
        wr(7'd7, 32'hAAAA_AA77, 3'b100); rd_expect(7'd7, 32'hBEEF_0077);
        wr(7'd7, 32'h0000_0099, 3'b111); rd_expect(7'd7, 32'h99EF_0077);
        wr(7'd7, 32'h0000_0055, 3'b101); rd_expect(7'd7, 32'h99EF_5577);

        // Read-during-write returns the old word, then the new one; strb 010 writes nothing.
        we = 1'b1; wr_addr = 7'd9; wr_din = 32'h1234_5678; wr_strb = 3'b000;
        rd_addr = 7'd9; rd_q.push_back(32'h0); rd_chk = 1'b1;
        tick();
        we = 1'b0; rd_q.push_back(32'h1234_5678);
        tick();
        rd_chk = 1'b0;
        wr(7'd9, 32'hFFFF_FFFF, 3'b010); rd_expect(7'd9, 32'h1234_5678);

        // Dump 1: preload i*3, ready held high.
        for (int i = 0; i < DEPTH; i++) wr(7'(i), 32'(i * 3), 3'b000);
        for (int i = 0; i < DEPTH; i++) dump_q.push_back({7'(i), 32'(i * 3)});
        dump_ready = 1'b1; dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        cnt = 0; t = 0; got = 0;
        while (t < 400 && got == 0) begin
            @(negedge clk);
            t++;
            if (t == 1) chk("dump1_valid_latency", {63'd0, dump_valid}, 64'd1);
            if (dump_valid || cnt > 0) cnt++;
            if (dump_done) got = 1;
        end
        chk("dump1_done_seen", 64'(got), 64'd1);
        chk("dump1_done_cycle", 64'(cnt), 64'd129);
        @(negedge clk);
        chk("dump1_done_pulse", {63'd0, dump_done}, 64'd0);
        chk("dump1_idle_busy",  {63'd0, dump_busy}, 64'd0);
        chk("dump1_queue_empty", 64'(dump_q.size()), 64'd0);
        tick();

        // Dump 2: ready toggles; core overwrites word 10 while it is stalled.
        for (int i = 0; i < DEPTH; i++)
            dump_q.push_back({7'(i), (i == 10) ? 32'hCAFE_F00D : 32'(i * 3)});
        dump_ready = 1'b1; dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        wrote = 1'b0; hold_chk = 1'b0; got = 0; t = 0;
        while (t < 600 && got == 0) begin
            t++;
            if (hold_chk) begin
                chk("dump2_addr_hold", {57'd0, dump_addr}, 64'd10);
                hold_chk = 1'b0;
            end
            if (dump_valid && dump_addr == 7'd10 && !wrote) begin
                dump_ready = 1'b0;
                we = 1'b1; wr_addr = 7'd10; wr_din = 32'hCAFE_F00D; wr_strb = 3'b000;
                wrote = 1'b1; hold_chk = 1'b1;
            end else begin
                we = 1'b0;
                dump_ready = ~dump_ready;
            end
            tick();
            if (dump_done) got = 1;
        end
        we = 1'b0; dump_ready = 1'b1;
        chk("dump2_stall_write", {63'd0, wrote}, 64'd1);
        chk("dump2_done_seen", 64'(got), 64'd1);
        chk("dump2_queue_empty", 64'(dump_q.size()), 64'd0);
        tick(); tick();

        // Dump 3: extra start while busy, reset when word 40 is presented.
        for (int i = 0; i < 40; i++)
            dump_q.push_back({7'(i), (i == 10) ? 32'hCAFE_F00D : 32'(i * 3)});
        done_before = done_seen;
        dump_ready = 1'b1; dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        extra = 1'b0; got = 0; t = 0;
        while (t < 300 && got == 0) begin
            t++;
            dump_start = 1'b0;
            if (dump_valid && dump_addr == 7'd20 && !extra) begin
                dump_start = 1'b1;
                extra = 1'b1;
            end
            if (dump_valid && dump_addr == 7'd40) begin
                dump_ready = 1'b0;
                rst = 1'b0;
                got = 1;
            end
            tick();
        end
        rst = 1'b1; dump_start = 1'b0; dump_ready = 1'b1;
        chk("dump3_reached_40", 64'(got), 64'd1);
        chk("dump3_valid", {63'd0, dump_valid}, 64'd0);
        chk("dump3_busy",  {63'd0, dump_busy},  64'd0);
        chk("dump3_done",  {63'd0, dump_done},  64'd0);
        chk("dump3_addr",  {57'd0, dump_addr},  64'd0);
        chk("dump3_data",  {32'd0, dump_data},  64'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("dump3_no_done_pulse", 64'(done_seen), 64'(done_before));
        chk("dump3_queue_empty", 64'(dump_q.size()), 64'd0);
        for (int i = 0; i < DEPTH; i++) rd_expect(7'(i), 32'h0);

        tick();
        chk("rd_queue_empty", 64'(rd_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
